ftw_estimator: RTL and testbench
================================

Name: ftw_estimator

Overview:
- Receive-side counterpart of the team's NCO: it takes the 8-bit sine sample stream the NCO produces and recovers the frequency tuning word that generated it.
- Rising zero crossings are detected with hysteresis, and the samples spanning PERIODS full cycles are counted.
- A sequential divider turns that count into an Iftw/Fftw pair with the same integer/fraction split as the NCO input.
- Used for loopback self-test of the NCO chain and for estimating the frequency of external tones.

Parameters:
- lutsize, 10, NCO LUT address width; integer FTW is lutsize+1 bits, phase modulus is 2^(lutsize+8).
- PERIODS, 16, cycles per measurement window; must be a power of two and at least 2.
- HYST, 8, hysteresis half-width around midscale, in LSBs.
- CNTW, 24, sample-counter width; this also sets the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  sample valid; a sample is consumed on any edge where en=1.
- sine  in  8  unsigned offset-binary sample; midscale is 128.
- Iftw  out  lutsize+1  integer part of the estimated FTW.
- Fftw  out  8  fractional part of the estimated FTW.
- ftw_valid  out  1  one-cycle pulse when Iftw/Fftw update.
- locked  out  1  high once the first window has completed without timeout.
- timeout  out  1  sticky flag: the last window overflowed the counter.

Behaviour:
- Reset: Iftw=0, Fftw=0, ftw_valid=0, locked=0, timeout=0. Acquisition FSM goes to SEEK; divider goes to IDLE; the armed flag and all counters clear.
- Reset mid-division aborts the division; no ftw_valid is produced.
- Crossing detector:
  - Arms when en=1 and sine < 128-HYST.
  - A crossing occurs on an en=1 sample where armed=1 and sine >= 128. That same edge disarms the detector.
  - Samples with en=0 are ignored entirely.
- Acquisition FSM:
  - SEEK: on a crossing, clear scnt=0 and pcnt=0, then go to MEASURE.
  - MEASURE: every en=1 sample increments scnt, including the crossing sample. Each crossing increments pcnt.
  - When a crossing makes pcnt==PERIODS, the window closes:
    - scnt+1 is handed to the divider;
    - scnt and pcnt restart at 0 on that same edge, so the closing crossing opens the next window and windows run back-to-back;
    - the FSM stays in MEASURE.
  - Timeout: if scnt reaches 2^CNTW-1 in MEASURE:
    - Iftw and Fftw go to 0, timeout=1, locked=0, ftw_valid pulses;
    - the FSM goes to SEEK.
- Divider:
  - Computes the unsigned quotient Q = (PERIODS << (lutsize+8)) / N, where N is the window sample count, truncated toward zero.
  - Restoring algorithm, one quotient bit per cycle, lutsize+9 iterations.
  - If N < PERIODS, the quotient is saturated to all ones and no division is performed.
  - Result mapping: Iftw = Q[lutsize+8:8], Fftw = Q[7:0].
- Latency: ftw_valid is asserted exactly lutsize+10 cycles after the edge that consumes the closing crossing sample.
  - On that same cycle, Iftw and Fftw update, locked goes to 1 and timeout clears.
  - Outputs hold until the next result.
- Overlap: hysteresis forces at least 2 samples per period, so a window is at least 2*PERIODS samples, which must exceed lutsize+10. This rule is checked by an elaboration assertion.
  - If a window still closes while the divider is busy, the new count is dropped; the current division completes.
- Timeout and closing crossing on the same edge: the closing crossing takes priority.

Decomposition:
- Package ftw_est_pkg holds:
  - MIDSCALE=128;
  - acq_state_t {SEEK, MEASURE};
  - div_state_t {IDLE, BUSY};
  - quotient-width function QW(lutsize)=lutsize+9.
- One sub-module, seq_divider: a generic unsigned restoring divider with start/busy/done and parameterised dividend, divisor and quotient widths.

Test Plan:
- Square-ish tone with period 64, en=1 always, lutsize=10 → after the second window: ftw_valid pulse, Iftw=16, Fftw=0, locked=1.
- Period 100 tone → Q=2621, so Iftw=10, Fftw=61. ftw_valid arrives exactly 20 cycles after the closing crossing.
- Period 64 tone with en toggling 1/0 every cycle → same result (Iftw=16, Fftw=0), which proves en=0 samples are ignored.
- Constant sine=200 with CNTW=12 → no crossing, FSM stays in SEEK, no ftw_valid.
- One crossing followed by constant 200 → ftw_valid with Iftw=0, Fftw=0, timeout=1, locked=0.
- Chatter within ±HYST of 128 on a period-64 tone → no extra crossings, result still Iftw=16.
- rst asserted mid-division → no ftw_valid, all outputs read 0 on the next cycle, and reacquisition succeeds afterwards.

Source files
------------

// File: rtl/ftw_est_pkg.sv
// Shared constants, state types and width helpers for the FTW estimator.
package ftw_est_pkg;

  localparam int MIDSCALE = 128;

  typedef enum logic {SEEK, MEASURE} acq_state_t;
  typedef enum logic {IDLE, BUSY} div_state_t;

  // Quotient width: integer FTW (lutsize+1 bits) plus 8 fraction bits.
  function automatic int QW(input int lutsize);
    return lutsize + 9;
  endfunction

endpackage

// File: rtl/ftw_estimator_if.sv
// Sample-in / estimate-out bundle of the FTW estimator.
interface ftw_estimator_if #(
  parameter int lutsize = 10
);
  logic             en;
  logic [7:0]       sine;
  logic [lutsize:0] Iftw;
  logic [7:0]       Fftw;
  logic             ftw_valid;
  logic             locked;
  logic             timeout;

  modport master (output en, sine, input Iftw, Fftw, ftw_valid, locked, timeout);
  modport slave  (input en, sine, output Iftw, Fftw, ftw_valid, locked, timeout);
endinterface

// File: rtl/seq_divider.sv
// Generic unsigned restoring divider, one quotient bit per cycle. The caller guarantees
// dividend >> QUOT_W < divisor, so the quotient always fits in QUOT_W bits.
module seq_divider
  import ftw_est_pkg::*;
#(
  parameter int DIVIDEND_W = 23,
  parameter int DIVISOR_W  = 24,
  parameter int QUOT_W     = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [QUOT_W-1:0]     quotient_o
);

  localparam int CW = $clog2(QUOT_W + 1);

  generate
    if (DIVIDEND_W - QUOT_W > DIVISOR_W) begin : g_bad_widths
      $error("seq_divider: dividend high part does not fit the remainder register");
    end
  endgenerate

  div_state_t           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic [DIVISOR_W-1:0] rem_q, rem_d;
  logic [DIVISOR_W-1:0] dvs_q, dvs_d;
  logic [QUOT_W-1:0]    quo_q, quo_d;
  logic [DIVISOR_W:0]   trial;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    trial   = {rem_q, quo_q[QUOT_W-1]};
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = BUSY;
          cnt_d   = CW'(QUOT_W);
          rem_d   = DIVISOR_W'(dividend_i >> QUOT_W);
          dvs_d   = divisor_i;
          quo_d   = dividend_i[QUOT_W-1:0];
        end
      end
      BUSY: begin
        if (trial >= {1'b0, dvs_q}) begin
          rem_d = DIVISOR_W'(trial - {1'b0, dvs_q});
          quo_d = {quo_q[QUOT_W-2:0], 1'b1};
        end else begin
          rem_d = trial[DIVISOR_W-1:0];
          quo_d = {quo_q[QUOT_W-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: clocked processes use non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // NOTE: datapath registers carry no reset; their contents only matter once done_o qualifies them.
  always_ff @(posedge clk) begin
    rem_q <= rem_d;
    dvs_q <= dvs_d;
    quo_q <= quo_d;
  end

  assign busy_o     = (state_q == BUSY);
  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/ftw_estimator.sv
// Recovers the NCO tuning word from its sine output: hysteretic rising-crossing detector,
// a back-to-back window counter over PERIODS cycles and a sequential divide to Iftw/Fftw.
module ftw_estimator
  import ftw_est_pkg::*;
#(
  parameter int lutsize = 10,
  parameter int PERIODS = 16,
  parameter int HYST    = 8,
  parameter int CNTW    = 24
) (
  input logic            clk,
  input logic            rst,
  ftw_estimator_if.slave bus
);

  localparam int QWID   = QW(lutsize);
  localparam int PCW    = (PERIODS > 1) ? $clog2(PERIODS) : 1;
  localparam int DIVD_W = PCW + lutsize + 9;
  localparam logic [DIVD_W-1:0] DIVIDEND  = DIVD_W'(PERIODS) << (lutsize + 8);
  localparam logic [7:0]        MID       = 8'(MIDSCALE);
  localparam logic [7:0]        LOW       = 8'(MIDSCALE - HYST);
  localparam logic [CNTW-1:0]   SCNT_TMO  = {CNTW{1'b1}} - CNTW'(1);
  localparam logic [CNTW-1:0]   N_MIN     = CNTW'(PERIODS);
  localparam logic [PCW-1:0]    PCNT_LAST = PCW'(PERIODS - 1);

  generate
    if ((PERIODS < 2) || ((PERIODS & (PERIODS - 1)) != 0)) begin : g_bad_periods
      $error("ftw_estimator: PERIODS must be a power of two and at least 2");
    end
    if (2 * PERIODS <= lutsize + 10) begin : g_bad_overlap
      $error("ftw_estimator: shortest window must outlast the divider latency");
    end
  endgenerate

  acq_state_t       state_q, state_d;
  logic             armed_q, armed_d;
  logic [CNTW-1:0]  scnt_q, scnt_d;
  logic [PCW-1:0]   pcnt_q, pcnt_d;
  logic             crossing, close_win, tmo_hit;
  logic             div_start, div_busy, div_done, sat_q;
  logic [CNTW-1:0]  n_win;
  logic [QWID-1:0]  div_quo;
  logic [lutsize:0] iftw_q;
  logic [7:0]       fftw_q;
  logic             valid_q, locked_q, timeout_q;

  // A crossing needs a prior sample below the hysteresis band and disarms on the same edge.
  always_comb begin
    armed_d  = armed_q;
    crossing = 1'b0;
    if (bus.en) begin
      if (armed_q && (bus.sine >= MID)) begin
        crossing = 1'b1;
        armed_d  = 1'b0;
      end else if (bus.sine < LOW) begin
        armed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEEK;
      armed_q <= 1'b0;
      scnt_q  <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      scnt_q  <= scnt_d;
      pcnt_q  <= pcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      SEEK: begin
        if (crossing) begin
          state_d = MEASURE;
          scnt_d  = '0;
          pcnt_d  = '0;
        end
      end
      MEASURE: begin
        if (close_win) begin
          scnt_d = '0;
          pcnt_d = '0;
        end else if (tmo_hit) begin
          state_d = SEEK;
          scnt_d  = '0;
          pcnt_d  = '0;
        end else if (bus.en) begin
          scnt_d = scnt_q + CNTW'(1);
          if (crossing) pcnt_d = pcnt_q + PCW'(1);
        end
      end
      default: state_d = SEEK;
    endcase
  end

  // Timeout fires on the sample that would bring scnt to all ones; a closing crossing wins.
  always_comb begin
    close_win = (state_q == MEASURE) && crossing && (pcnt_q == PCNT_LAST);
    tmo_hit   = (state_q == MEASURE) && bus.en && !close_win && (scnt_q == SCNT_TMO);
    n_win     = scnt_q + CNTW'(1);
    div_start = close_win && !div_busy;
  end

  seq_divider #(
    .DIVIDEND_W (DIVD_W),
    .DIVISOR_W  (CNTW),
    .QUOT_W     (QWID)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i (DIVIDEND),
    .divisor_i  (n_win),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  // Windows shorter than PERIODS would overflow the quotient, so they saturate instead.
  always_ff @(posedge clk) begin
    if (rst)            sat_q <= 1'b0;
    else if (div_start) sat_q <= (n_win < N_MIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iftw_q    <= '0;
      fftw_q    <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (div_done) begin
        {iftw_q, fftw_q} <= sat_q ? {QWID{1'b1}} : div_quo;
        valid_q   <= 1'b1;
        locked_q  <= 1'b1;
        timeout_q <= 1'b0;
      end else if (tmo_hit) begin
        iftw_q    <= '0;
        fftw_q    <= '0;
        valid_q   <= 1'b1;
        locked_q  <= 1'b0;
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.Iftw      = iftw_q;
  assign bus.Fftw      = fftw_q;
  assign bus.ftw_valid = valid_q;
  assign bus.locked    = locked_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_ftw_estimator.sv
// Directed and randomized tone tests for ftw_estimator against an arithmetic frequency model.
module tb_ftw_estimator;

  localparam int LUTSIZE = 10;
  localparam int PERIODS = 16;
  localparam int HYST    = 8;
  localparam int CNTW    = 12;
  localparam int LATENCY = LUTSIZE + 10;
  localparam int BUDGET  = 40000;

  logic clk = 1'b0;
  logic rst;

  ftw_estimator_if #(.lutsize(LUTSIZE)) bus ();

  ftw_estimator #(
    .lutsize (LUTSIZE),
    .PERIODS (PERIODS),
    .HYST    (HYST),
    .CNTW    (CNTW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int tone_lo  = 40;
  int tone_hi  = 200;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Sample k of a tone of the given period; phase 0 is the rising crossing.
  function automatic logic [7:0] tone(input int k, input int period, input bit chatter);
    int ph;
    int half;
    ph   = k % period;
    half = period / 2;
    if (chatter) begin
      if (ph == 0)        return 8'd129;
      if (ph == 1)        return 8'd124;
      if (ph == 2)        return 8'd131;
      if (ph == 3)        return 8'd121;
      if (ph == half)     return 8'd127;
      if (ph == half + 1) return 8'd134;
      if (ph == half + 2) return 8'd122;
      if (ph == half + 3) return 8'd126;
    end
    return (ph < half) ? 8'(tone_hi) : 8'(tone_lo);
  endfunction

  // A window spans PERIODS full cycles of valid samples: FTW = (PERIODS * 2^(lutsize+8)) / N.
  function automatic int expected_q(input int period);
    return (PERIODS * (1 << (LUTSIZE + 8))) / (PERIODS * period);
  endfunction

  task automatic do_reset();
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.sine = 8'd128;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // en_mode: 0 always valid, 1 alternate, 2 random. After 'want' results either return
  // (extra < 0) or run on to the next window close and return 'extra' cycles after it.
  task automatic drive_tone(input int period, input bit chatter, input int en_mode,
                            input int want, input int extra, input string tag);
    int k, c, cyc, got, after, lat, exp_q;
    int close_q[$];
    logic e;
    k     = period / 2;
    cyc   = 0;
    got   = 0;
    after = -1;
    exp_q = expected_q(period);
    forever begin
      case (en_mode)
        0:       e = 1'b1;
        1:       e = (cyc % 2 == 0);
        default: e = 1'($urandom_range(0, 1));
      endcase
      bus.en   = e;
      bus.sine = e ? tone(k, period, chatter) : 8'($urandom);
      @(posedge clk);
      #1;
      cyc++;
      if (e) begin
        if ((k % period == 0) && (k >= period)) begin
          c = k / period;
          if ((c > 1) && ((c - 1) % PERIODS == 0)) begin
            close_q.push_back(cyc);
            if ((got >= want) && (extra >= 0) && (after < 0)) after = extra;
          end
        end
        k++;
      end
      if (bus.ftw_valid === 1'b1) begin
        if (close_q.size() == 0) begin
          check({tag, "_valid_without_close"}, bus.ftw_valid, 0);
        end else begin
          lat = cyc - close_q.pop_front();
          check({tag, "_latency"}, lat, LATENCY);
          check({tag, "_iftw"}, bus.Iftw, exp_q / 256);
          check({tag, "_fftw"}, bus.Fftw, exp_q % 256);
          check({tag, "_locked"}, bus.locked, 1);
          check({tag, "_timeout"}, bus.timeout, 0);
          got++;
        end
      end
      if ((got >= want) && (extra < 0)) break;
      if (after == 0) break;
      if (after > 0) after--;
      if (cyc >= BUDGET) begin
        check({tag, "_results_in_budget"}, got, want);
        break;
      end
    end
  endtask

  initial begin
    int nv, cyc, seen, p;

    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.sine = 8'd128;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", bus.ftw_valid, 0);
    check("reset_iftw", bus.Iftw, 0);
    check("reset_fftw", bus.Fftw, 0);
    check("reset_locked", bus.locked, 0);
    check("reset_timeout", bus.timeout, 0);
    rst = 1'b0;

    drive_tone(64, 1'b0, 0, 2, -1, "p64");

    do_reset();
    drive_tone(100, 1'b0, 0, 1, -1, "p100");

    do_reset();
    drive_tone(64, 1'b0, 1, 1, -1, "p64_en_toggle");

    do_reset();
    drive_tone(64, 1'b1, 0, 1, -1, "p64_chatter");

    for (int r = 0; r < 2; r++) begin
      do_reset();
      tone_lo = $urandom_range(0, 127 - HYST);
      tone_hi = $urandom_range(128, 255);
      p       = $urandom_range(40, 150);
      drive_tone(p, 1'b0, 2, 1, -1, "rand_tone");
    end
    tone_lo = 40;
    tone_hi = 200;

    // Never below the hysteresis band: no crossing, so no window and no timeout.
    do_reset();
    bus.en   = 1'b1;
    bus.sine = 8'd200;
    nv       = 0;
    repeat (5000) begin
      @(posedge clk);
      #1;
      if (bus.ftw_valid === 1'b1) nv++;
    end
    check("const_no_valid", nv, 0);
    check("const_timeout", bus.timeout, 0);
    check("const_locked", bus.locked, 0);

    // One crossing, then stuck high: the sample bringing scnt to 2^CNTW-1 times out.
    do_reset();
    bus.en   = 1'b1;
    bus.sine = 8'd40;
    repeat (3) @(posedge clk);
    #1;
    bus.sine = 8'd200;
    @(posedge clk);
    #1;
    cyc  = 0;
    seen = 0;
    while (cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.ftw_valid === 1'b1) begin
        seen = 1;
        check("tmo_latency", cyc, (1 << CNTW) - 1);
        check("tmo_iftw", bus.Iftw, 0);
        check("tmo_fftw", bus.Fftw, 0);
        check("tmo_flag", bus.timeout, 1);
        check("tmo_locked", bus.locked, 0);
        break;
      end
    end
    check("tmo_seen", seen, 1);

    drive_tone(64, 1'b0, 0, 1, -1, "recover");

    // Lose the tone while locked: outputs drop to zero and timeout sticks.
    bus.en   = 1'b1;
    bus.sine = 8'd200;
    seen     = 0;
    cyc      = 0;
    while (cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.ftw_valid === 1'b1) begin
        seen = 1;
        check("lost_iftw", bus.Iftw, 0);
        check("lost_fftw", bus.Fftw, 0);
        check("lost_timeout", bus.timeout, 1);
        check("lost_locked", bus.locked, 0);
        break;
      end
    end
    check("lost_seen", seen, 1);
    bus.en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("lost_timeout_sticky", bus.timeout, 1);

    // Reset while the second window's division is in flight.
    do_reset();
    drive_tone(64, 1'b0, 0, 1, 5, "pre_abort");
    rst    = 1'b1;
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    check("abort_iftw", bus.Iftw, 0);
    check("abort_fftw", bus.Fftw, 0);
    check("abort_valid", bus.ftw_valid, 0);
    check("abort_locked", bus.locked, 0);
    check("abort_timeout", bus.timeout, 0);
    rst = 1'b0;
    nv  = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.ftw_valid === 1'b1) nv++;
    end
    check("abort_no_valid", nv, 0);
    drive_tone(100, 1'b0, 0, 1, -1, "reacquire");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
